// File: rtl/trace_capture.sv
// trace_capture
// Commit-trace and stop-condition unit placed beside the CPU core. Each
// retirement that qualifies is buffered in a first-word-fall-through FIFO
// that is drained through a valid/ready port. A sticky halt request is raised
// on a PC breakpoint, when the cycle limit is reached, or on FIFO overflow
// (when overflow-halt is selected).
//
// Ports
//   clk_i, rstn_i            clock, async active-low reset
//   en_i, mode_i, clear_i    enable; mode[0]=rf_we filter, mode[1]=halt on full; sync clear
//   retire_i, pc_i, instr_i  retiring instruction
//   rf_we_i, rf_waddr_i, rf_wdata_i  register write of that instruction
//   bp_addr_i, bp_en_i       breakpoint PCs and per-channel enables
//   cyc_limit_i              halt after this many enabled cycles (0 = off)
//   halt_o, halt_cause_o, bp_idx_o   sticky stop request and its cause
//   out_*                    FIFO head entry with valid/ready handshake
//   count_o, drop_cnt_o, cycle_cnt_o status counters
//
// state  | meaning
// S_RUN  | monitoring, pushes allowed
// S_HALT | stop requested, no pushes, cycle counter frozen; drain still works
module trace_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int NUM_BP = 2,
  parameter int CYC_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       en_i,
  input  logic [1:0]                 mode_i,
  input  logic                       clear_i,
  input  logic                       retire_i,
  input  logic [DATA_W-1:0]          pc_i,
  input  logic [DATA_W-1:0]          instr_i,
  input  logic                       rf_we_i,
  input  logic [4:0]                 rf_waddr_i,
  input  logic [DATA_W-1:0]          rf_wdata_i,
  input  logic [NUM_BP*DATA_W-1:0]   bp_addr_i,
  input  logic [NUM_BP-1:0]          bp_en_i,
  input  logic [CYC_W-1:0]           cyc_limit_i,
  output logic                       halt_o,
  output logic [1:0]                 halt_cause_o,
  output logic [$clog2(NUM_BP)-1:0]  bp_idx_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_pc_o,
  output logic [DATA_W-1:0]          out_instr_o,
  output logic                       out_we_o,
  output logic [4:0]                 out_waddr_o,
  output logic [DATA_W-1:0]          out_wdata_o,
  output logic [CYC_W-1:0]           out_cycle_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                drop_cnt_o,
  output logic [CYC_W-1:0]           cycle_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NUM_BP);
  localparam int EW = 3*DATA_W + 6 + CYC_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q, count_d;
  logic [15:0]       drop_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [1:0]        cause_q;
  logic [BW-1:0]     bp_idx_q;

  logic active, qual, pop, space, push, full_evt, ovf_halt;
  logic bp_any, bp_hit, cyc_hit, halt_evt;
  logic [BW-1:0] bp_sel;

  assign active   = en_i & (state_q == S_RUN) & ~clear_i;
  assign qual     = active & retire_i & (~mode_i[0] | rf_we_i);
  assign pop      = (count_q != '0) & out_ready_i;
  assign space    = (count_q != DEPTH_C) | pop;
  assign push     = qual & space;
  assign full_evt = qual & ~space;
  assign ovf_halt = full_evt & mode_i[1];
  assign cyc_hit  = active & (cyc_limit_i != '0) & (cyc_q == cyc_limit_i - CYC_W'(1));
  assign bp_hit   = active & retire_i & bp_any;
  assign halt_evt = bp_hit | cyc_hit | ovf_halt;

  // Descending scan so the lowest matching channel is the one left selected.
  always_comb begin
    bp_any = 1'b0;
    bp_sel = '0;
    for (int i = NUM_BP-1; i >= 0; i--) begin
      if (bp_en_i[i] && (pc_i == bp_addr_i[i*DATA_W +: DATA_W])) begin
        bp_any = 1'b1;
        bp_sel = BW'(i);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (!clear_i && halt_evt) state_d = S_HALT;
      S_HALT:  if (clear_i)              state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    halt_o = (state_q == S_HALT);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cause_q  <= 2'b00;
      bp_idx_q <= '0;
    end else if (clear_i) begin
      cause_q  <= 2'b00;
      bp_idx_q <= '0;
    end else if (halt_evt) begin
      if (bp_hit) begin
        cause_q  <= 2'b01;
        bp_idx_q <= bp_sel;
      end else if (cyc_hit) begin
        cause_q  <= 2'b10;
      end else begin
        cause_q  <= 2'b11;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      cyc_q   <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      cyc_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      if (full_evt && !mode_i[1] && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (active && !(&cyc_q)) cyc_q <= cyc_q + CYC_W'(1);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {pc_i, instr_i, rf_we_i, rf_waddr_i, rf_wdata_i, cyc_q};
  end

  assign {out_pc_o, out_instr_o, out_we_o, out_waddr_o, out_wdata_o, out_cycle_o} = mem_q[rptr_q];
  assign out_valid_o  = (count_q != '0);
  assign count_o      = count_q;
  assign drop_cnt_o   = drop_q;
  assign cycle_cnt_o  = cyc_q;
  assign halt_cause_o = cause_q;
  assign bp_idx_o     = bp_idx_q;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int NBP = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rstn, en, clear, retire, rf_we, out_ready;
  logic [1:0] mode;
  logic [DW-1:0] pc, instr, rf_wdata;
  logic [4:0] rf_waddr;
  logic [NBP*DW-1:0] bp_addr;
  logic [NBP-1:0] bp_en;
  logic [CW-1:0] cyc_limit;
  logic halt, out_valid, out_we;
  logic [1:0] halt_cause;
  logic [0:0] bp_idx;
  logic [DW-1:0] out_pc, out_instr, out_wdata;
  logic [4:0] out_waddr;
  logic [CW-1:0] out_cycle, cycle_cnt;
  logic [3:0] count;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  trace_capture #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_BP(NBP), .CYC_W(CW)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode), .clear_i(clear),
    .retire_i(retire), .pc_i(pc), .instr_i(instr), .rf_we_i(rf_we),
    .rf_waddr_i(rf_waddr), .rf_wdata_i(rf_wdata), .bp_addr_i(bp_addr),
    .bp_en_i(bp_en), .cyc_limit_i(cyc_limit), .halt_o(halt),
    .halt_cause_o(halt_cause), .bp_idx_o(bp_idx), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_pc_o(out_pc), .out_instr_o(out_instr),
    .out_we_o(out_we), .out_waddr_o(out_waddr), .out_wdata_o(out_wdata),
    .out_cycle_o(out_cycle), .count_o(count), .drop_cnt_o(drop_cnt),
    .cycle_cnt_o(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic          we;
    logic [4:0]    wa;
    logic [DW-1:0] wd;
    logic [CW-1:0] cyc;
  } ent_t;

  ent_t exp_q[$];

  // reference state
  int m_count, m_drop, m_cyc, m_cause, m_idx;
  bit m_halt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    exp_q.delete();
    m_count = 0; m_drop = 0; m_cyc = 0; m_cause = 0; m_idx = 0; m_halt = 0;
  endfunction

  // Reference model: applies the behavioural rules once per clock edge.
  initial begin : model
    bit act, pop, qual, spc, full;
    int hit;
    ent_t e;
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn || clear) begin
        m_reset();
      end else begin
        act  = en && !m_halt;
        pop  = (m_count > 0) && out_ready;
        qual = act && retire && (!mode[0] || rf_we);
        spc  = (m_count < DEPTH) || pop;
        full = qual && !spc;
        hit  = -1;
        if (act && retire)
          for (int i = 0; i < NBP; i++)
            if (hit < 0 && bp_en[i] && pc == bp_addr[i*DW +: DW]) hit = i;
        if (pop) m_count--;
        if (qual && spc) begin
          e.pc = pc; e.instr = instr; e.we = rf_we; e.wa = rf_waddr;
          e.wd = rf_wdata; e.cyc = CW'(m_cyc);
          exp_q.push_back(e);
          m_count++;
        end
        if (full && !mode[1] && m_drop < 65535) m_drop++;
        if (hit >= 0) begin m_halt = 1; m_cause = 1; m_idx = hit; end
        else if (act && cyc_limit != 0 && m_cyc == int'(cyc_limit) - 1) begin
          m_halt = 1; m_cause = 2;
        end else if (full && mode[1]) begin m_halt = 1; m_cause = 3; end
        if (act && m_cyc < 65535) m_cyc++;
      end
    end
  end

  // Monitor: compares status each cycle and pops the scoreboard on every handshake.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("count", count, m_count);
        chk("out_valid", out_valid, m_count != 0);
        chk("halt", halt, m_halt);
        chk("halt_cause", halt_cause, m_cause);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("cycle_cnt", cycle_cnt, m_cyc);
        if (m_cause == 1) chk("bp_idx", bp_idx, m_idx);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_entry", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
            chk("out_we", out_we, e.we);
            chk("out_waddr", out_waddr, e.wa);
            chk("out_wdata", out_wdata, e.wd);
            chk("out_cycle", out_cycle, e.cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ret(input logic [DW-1:0] p, input logic we);
    retire = 1; pc = p; instr = $urandom; rf_we = we;
    rf_waddr = 5'($urandom); rf_wdata = $urandom;
    step();
    retire = 0;
  endtask

  task automatic do_clear();
    clear = 1; step(); clear = 0;
  endtask

  initial begin : driver
    rstn = 0; en = 0; clear = 0; retire = 0; rf_we = 0; out_ready = 0;
    mode = 2'b00; pc = '0; instr = '0; rf_waddr = '0; rf_wdata = '0;
    bp_addr = '0; bp_en = '0; cyc_limit = '0;
    #23;
    chk("reset_count", count, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_halt", halt, 0);
    rstn = 1;
    step();

    // five ordered retirements, then drain
    en = 1;
    for (int i = 0; i < 5; i++) ret(DW'(i*4), 1'b1);
    chk("fill5_count", count, 5);
    chk("fill5_head_pc", out_pc, 0);
    chk("fill5_head_cyc", out_cycle, 0);
    out_ready = 1; step(7); out_ready = 0;

    // breakpoint on channel 1
    do_clear();
    bp_addr = {32'h48, 32'h1000}; bp_en = 2'b10;
    for (int i = 0; i < 5; i++) ret(DW'(32'h40 + i*4), 1'b1);
    chk("bp_halt", halt, 1);
    chk("bp_cause", halt_cause, 1);
    chk("bp_idx_dir", bp_idx, 1);
    chk("bp_count", count, 3);
    out_ready = 1; step(5); out_ready = 0;
    bp_en = '0;

    // cycle limit
    do_clear();
    cyc_limit = 16'd1000;
    for (int k = 0; k < 1100 && !halt; k++) step();
    chk("cyc_halt", halt, 1);
    chk("cyc_cause", halt_cause, 2);
    chk("cyc_cnt", cycle_cnt, 1000);
    cyc_limit = '0;

    // overflow with halt, then with drop
    do_clear();
    mode = 2'b10;
    for (int i = 0; i < DEPTH+1; i++) ret(DW'(32'h100 + i*4), 1'b1);
    chk("ovf_count", count, DEPTH);
    chk("ovf_cause", halt_cause, 3);
    do_clear();
    mode = 2'b00;
    for (int i = 0; i < DEPTH+1; i++) ret(DW'(32'h200 + i*4), 1'b1);
    chk("drop_count", count, DEPTH);
    chk("drop_one", drop_cnt, 1);
    chk("drop_nohalt", halt, 0);
    // push and pop together while full
    out_ready = 1;
    ret(32'h300, 1'b1);
    chk("fullpp_count", count, DEPTH);
    step(DEPTH+2); out_ready = 0;

    // rf_we filter
    mode = 2'b01;
    for (int i = 0; i < 10; i++) ret(DW'(32'h400 + i*4), 1'($urandom));
    out_ready = 1; step(DEPTH+2); out_ready = 0;

    // clear during push
    mode = 2'b00;
    ret(32'h500, 1'b1); ret(32'h504, 1'b1);
    retire = 1; pc = 32'h508; clear = 1; step(); clear = 0; retire = 0;
    chk("clr_count", count, 0);
    chk("clr_valid", out_valid, 0);

    // randomized traffic
    bp_addr = {32'h48, 32'h40};
    for (int k = 0; k < 800; k++) begin
      en = ($urandom_range(0, 9) != 0);
      retire = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: pc = 32'h40;
        1: pc = 32'h48;
        default: pc = {$urandom} & 32'h0000_0ffc;
      endcase
      instr = $urandom; rf_we = 1'($urandom); rf_waddr = 5'($urandom);
      rf_wdata = $urandom;
      out_ready = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) begin
        mode = 2'($urandom);
        bp_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        cyc_limit = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 80)) : '0;
        if ($urandom_range(0, 3) == 0) bp_addr = {32'h40, 32'h40};
        else bp_addr = {32'h48, 32'h40};
      end
      step();
    end
    retire = 0; clear = 0; en = 1; bp_en = '0; cyc_limit = '0; mode = 2'b00;
    do_clear();

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) ret(DW'(32'h600 + i*4), 1'b1);
    out_ready = 1; step();
    #2 rstn = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", count, 0);
    @(posedge clk); #2 rstn = 1;
    step(3);
    chk("post_rst_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
# trace_capture

Synthesizable commit-trace and stop-condition unit that sits beside the single-cycle CPU core and observes each retired instruction (PC, instruction word, register-file write). It buffers qualifying retirements in a parametrised first-word-fall-through FIFO with a valid/ready drain port. It raises a sticky halt request on PC breakpoints, a cycle limit or FIFO overflow. This moves the per-cycle trace dump and stop-on-PC / stop-on-count checks from simulation into hardware, with multiple breakpoint channels and a filter mode.

## Interface
- DATA_W, 32, width of PC, instruction and write data
- DEPTH, 16, FIFO entries; power of two, at least 2
- NUM_BP, 2, breakpoint channels; at least 2
- CYC_W, 16, cycle counter width
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- en  in  1  capture/monitor enable
- mode  in  2  bit0=1: record only retirements with rf_we=1; bit1=1: halt on FIFO full, 0: drop and count
- clear  in  1  synchronous clear of FIFO, halt, counters
- retire  in  1  one instruction retires this cycle
- pc, instr  in  DATA_W each  retiring instruction
- rf_we  in  1, rf_waddr  in  5, rf_wdata  in  DATA_W  register write of retiring instruction
- bp_addr  in  NUM_BP*DATA_W  breakpoint PCs; channel i at bits [i*DATA_W +: DATA_W]
- bp_en  in  NUM_BP  per-channel enable
- cyc_limit  in  CYC_W  halt after this many enabled cycles; 0 disables
- halt  out  1  sticky stop request to the core
- halt_cause  out  2  00 none, 01 breakpoint, 10 cycle limit, 11 FIFO full
- bp_idx  out  $clog2(NUM_BP)  channel that caused a breakpoint halt
- out_valid  out  1, out_ready  in  1  drain handshake
- out_pc, out_instr  out  DATA_W; out_we  out  1; out_waddr  out  5; out_wdata  out  DATA_W; out_cycle  out  CYC_W  head entry
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_cnt  out  16  saturating count of dropped entries
- cycle_cnt  out  CYC_W  enabled-cycle counter

## Operation
- Active cycle: en=1, halt=0, clear=0.
- cycle_cnt increments every active cycle and saturates at all-ones.
- Qualifying retirement: the cycle is active, retire=1, and (mode[0]=0 or rf_we=1).
- pop = out_valid & out_ready.
- space = (count<DEPTH) | pop.
- Push on a qualifying retirement with space. The entry stores pc, instr, rf_we, rf_waddr, rf_wdata and the pre-increment cycle_cnt.
- Breakpoint: active cycle, retire=1, bp_en[i]=1 and pc==bp_addr[i]. The instruction is still pushed if it qualifies and there is space. The lowest matching i is latched into bp_idx.
- Cycle limit: cyc_limit!=0 and cycle_cnt==cyc_limit-1 in an active cycle.
- FIFO full event: qualifying retirement with no space.
  - mode[1]=1: entry discarded, halt with cause 11.
  - mode[1]=0: entry discarded, drop_cnt increments (saturating at 16'hFFFF), no halt.
- Halt-cause priority when events coincide: breakpoint > cycle limit > full.
- halt and halt_cause are sticky until clear or reset. While halted, nothing is pushed and cycle_cnt holds.
- Draining continues while halted.
- out_valid = (count!=0). out_* show the head entry and are undefined when out_valid=0.
- Simultaneous push and pop: both take effect and count is unchanged. Pointers wrap modulo DEPTH.
- clear has priority over everything, including a concurrent push or pop. It empties the FIFO and zeroes halt, halt_cause, bp_idx, cycle_cnt and drop_cnt.
- Reset (async, rstn=0): same zero state as clear, count=0, out_valid=0. Reset mid-drain discards all entries.

## Timing
- Push-to-visible latency: 1 cycle. An entry pushed at edge N has out_valid=1 after edge N.
- Halt latency: halt and halt_cause update at the edge ending the triggering cycle. The triggering instruction is the last one recorded.
- count, drop_cnt and cycle_cnt are registered and reflect edge N after edge N.
- Handshake: an entry leaves at any edge where out_valid & out_ready. out_ready may be held high continuously. out_* change only after a pop or a push into an empty FIFO.
- With en=0, all counters and halt hold and no pushes occur.

## Test plan
- Reset, en=1, mode=00, 5 retirements at pc 0x00,0x04,…,0x10 with out_ready=0 -> count=5. Draining yields pc 0x00..0x10 in order with out_cycle 0..4.
- bp_addr ch1=0x48, bp_en=2'b10, retire through pc 0x48 -> halt=1 and halt_cause=01 at the next edge, bp_idx=1. The last FIFO entry has pc 0x48. Later retirements are ignored.
- cyc_limit=1000, retire=0 -> halt with cause 10 after 1000 active cycles, cycle_cnt=1000.
- DEPTH=4, mode=10, 5 retirements, no drain -> 4 entries stored, halt cause 11 at the 5th. Repeating with mode=00 gives drop_cnt=1 and no halt.
- Full FIFO with push and pop in the same cycle -> count stays 4 and the new entry appears at the tail. mode=01 with rf_we toggling -> only rf_we=1 retirements are recorded.
- clear asserted during a push -> count=0, halt=0, entry not stored. rstn pulsed low mid-drain -> out_valid=0 immediately.
